control_sequencer: RTL and testbench

//  Hardwired Moore control unit for the Phase 1 datapath. Drives the bus-out/latch-in strobes, ALU op_code and
//  one-hot register selects per T-state. Runs fetch (T0-T2) then a 3-op register ALU instruction (T3-T5/T6).

---
 rtl/control_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch (T0-T2) plus 3-operand register ALU execute (T3-T6),
// with a fixed-latency memory wait after T1 and a retired-instruction counter.
module control_sequencer #(
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Run,
    input  logic [31:0]      ir_q,
    output logic             PCout,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             MDRout,
    output logic             MARin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             ZLowIn,
    output logic             ZHighIn,
    output logic             HIin,
    output logic             LOin,
    output logic             IncPC,
    output logic             Read,
    output logic [4:0]       op_code,
    output logic [15:0]      Rin,
    output logic [15:0]      Rout,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned WCNT_W = 4;

    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_MUL  = 5'b01111;
    localparam logic [4:0] OPC_DIV  = 5'b10000;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_T0     = 4'd1,
        S_T1     = 4'd2,
        S_T1W    = 4'd3,
        S_T2     = 4'd4,
        S_T3     = 4'd5,
        S_T4     = 4'd6,
        S_T5     = 4'd7,
        S_T6     = 4'd8,
        S_HALTED = 4'd9
    } state_t;

    state_t            state, state_n;
    logic [WCNT_W-1:0] wcnt, wcnt_n;
    logic              retire;

    logic [4:0] opc;
    logic [3:0] ra, rb, rc;
    logic       ir_unused;
    logic [4:0] alu_op;
    logic       is_alu, is_muldiv, is_halt;

    assign opc       = ir_q[31:27];
    assign ra        = ir_q[26:23];
    assign rb        = ir_q[22:19];
    assign rc        = ir_q[18:15];
    assign ir_unused = ^ir_q[14:0];

    // Opcode decode: ALU mapping, legality, long-result (MUL/DIV) and HALT
    always_comb begin
        alu_op    = 5'b00000;
        is_alu    = 1'b1;
        is_muldiv = 1'b0;
        is_halt   = 1'b0;
        case (opc)
            OPC_ADD:  alu_op = 5'b00000;
            OPC_SUB:  alu_op = 5'b00001;
            OPC_AND:  alu_op = 5'b00010;
            OPC_OR:   alu_op = 5'b00011;
            OPC_MUL:  begin alu_op = 5'b00100; is_muldiv = 1'b1; end
            OPC_DIV:  begin alu_op = 5'b00101; is_muldiv = 1'b1; end
            OPC_HALT: begin is_alu = 1'b0; is_halt = 1'b1; end
            default:  is_alu = 1'b0;
        endcase
    end

    // Next state; retire marks the END edge where Run is resampled
    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        retire  = 1'b0;
        case (state)
            S_IDLE: if (Run) state_n = S_T0;
            S_T0:   state_n = S_T1;
            S_T1: begin
                if (MEM_WAIT == 0) begin
                    state_n = S_T2;
                end else begin
                    state_n = S_T1W;
                    wcnt_n  = WCNT_W'(MEM_WAIT - 1);
                end
            end
            S_T1W: begin
                if (wcnt == '0) state_n = S_T2;
                else            wcnt_n  = wcnt - WCNT_W'(1);
            end
            S_T2: state_n = S_T3;
            S_T3: begin
                if (is_halt)     state_n = S_HALTED;
                else if (!is_alu) retire = 1'b1;
                else             state_n = S_T4;
            end
            S_T4: state_n = S_T5;
            S_T5: begin
                if (is_muldiv) state_n = S_T6;
                else           retire  = 1'b1;
            end
            S_T6:     retire  = 1'b1;
            S_HALTED: state_n = S_HALTED;
            default:  state_n = S_IDLE;
        endcase
        if (retire) state_n = Run ? S_T0 : S_IDLE;
    end

    // Strobes decoded from the current state (and the latched IR)
    always_comb begin
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        ZLowIn   = 1'b0;
        ZHighIn  = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        op_code  = 5'b00000;
        Rin      = 16'h0000;
        Rout     = 16'h0000;
        busy     = 1'b0;
        halted   = 1'b0;
        illegal  = 1'b0;
        case (state)
            S_T0: begin
                busy = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
            end
            S_T1: begin
                busy = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            S_T1W: begin
                busy = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                busy = 1'b1; MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                busy    = 1'b1;
                illegal = !is_alu && !is_halt;
                if (is_alu) begin
                    Rout = 16'h0001 << rb;
                    Yin  = 1'b1;
                end
            end
            S_T4: begin
                busy    = 1'b1;
                Rout    = 16'h0001 << rc;
                op_code = alu_op;
                ZLowIn  = 1'b1;
                ZHighIn = is_muldiv;
            end
            S_T5: begin
                busy    = 1'b1;
                Zlowout = 1'b1;
                if (is_muldiv) LOin = 1'b1;
                else           Rin  = 16'h0001 << ra;
            end
            S_T6: begin
                busy = 1'b1; Zhighout = 1'b1; HIin = 1'b1;
            end
            S_HALTED: halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state       <= S_IDLE;
            wcnt        <= '0;
            instr_count <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            if (retire) instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the selected DUT instance.
module tb_control_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe vector bit positions
    localparam logic [14:0] S_PCOUT    = 15'(1) << 14;
    localparam logic [14:0] S_ZLOWOUT  = 15'(1) << 13;
    localparam logic [14:0] S_ZHIGHOUT = 15'(1) << 12;
    localparam logic [14:0] S_MDROUT   = 15'(1) << 11;
    localparam logic [14:0] S_MARIN    = 15'(1) << 10;
    localparam logic [14:0] S_PCIN     = 15'(1) << 9;
    localparam logic [14:0] S_MDRIN    = 15'(1) << 8;
    localparam logic [14:0] S_IRIN     = 15'(1) << 7;
    localparam logic [14:0] S_YIN      = 15'(1) << 6;
    localparam logic [14:0] S_ZLOWIN   = 15'(1) << 5;
    localparam logic [14:0] S_ZHIGHIN  = 15'(1) << 4;
    localparam logic [14:0] S_HIIN     = 15'(1) << 3;
    localparam logic [14:0] S_LOIN     = 15'(1) << 2;
    localparam logic [14:0] S_INCPC    = 15'(1) << 1;
    localparam logic [14:0] S_READ     = 15'(1);

    localparam logic [14:0] E_T0  = S_PCOUT | S_MARIN | S_INCPC | S_ZLOWIN;
    localparam logic [14:0] E_T1  = S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN;
    localparam logic [14:0] E_T1W = S_READ | S_MDRIN;
    localparam logic [14:0] E_T2  = S_MDROUT | S_IRIN;

    localparam logic [31:0] IR_AND  = 32'h28918000;
    localparam logic [31:0] IR_MUL  = {5'b01111, 4'd4, 4'd5, 4'd6, 15'd0};
    localparam logic [31:0] IR_ILL  = {5'b11111, 27'd0};
    localparam logic [31:0] IR_HALT = {5'b11011, 27'd0};
    localparam logic [31:0] IR_SUB  = {5'b00100, 4'd0, 4'd7, 4'd15, 15'd0};

    logic        clear0, run0, clear1, run1;
    logic [31:0] ir0, ir1;
    wire  [14:0] stb0, stb1;
    wire  [4:0]  op0, op1;
    wire  [15:0] rin0, rout0, rin1, rout1;
    wire         busy0, halted0, ill0, busy1, halted1, ill1;
    wire  [15:0] cnt0;
    wire  [1:0]  cnt1;

    control_sequencer #(.MEM_WAIT(0), .CNT_W(16)) dut0 (
        .Clock(clk), .Clear(clear0), .Run(run0), .ir_q(ir0),
        .PCout(stb0[14]), .Zlowout(stb0[13]), .Zhighout(stb0[12]), .MDRout(stb0[11]),
        .MARin(stb0[10]), .PCin(stb0[9]), .MDRin(stb0[8]), .IRin(stb0[7]),
        .Yin(stb0[6]), .ZLowIn(stb0[5]), .ZHighIn(stb0[4]), .HIin(stb0[3]),
        .LOin(stb0[2]), .IncPC(stb0[1]), .Read(stb0[0]),
        .op_code(op0), .Rin(rin0), .Rout(rout0),
        .busy(busy0), .halted(halted0), .illegal(ill0), .instr_count(cnt0)
    );

    control_sequencer #(.MEM_WAIT(3), .CNT_W(2)) dut1 (
        .Clock(clk), .Clear(clear1), .Run(run1), .ir_q(ir1),
        .PCout(stb1[14]), .Zlowout(stb1[13]), .Zhighout(stb1[12]), .MDRout(stb1[11]),
        .MARin(stb1[10]), .PCin(stb1[9]), .MDRin(stb1[8]), .IRin(stb1[7]),
        .Yin(stb1[6]), .ZLowIn(stb1[5]), .ZHighIn(stb1[4]), .HIin(stb1[3]),
        .LOin(stb1[2]), .IncPC(stb1[1]), .Read(stb1[0]),
        .op_code(op1), .Rin(rin1), .Rout(rout1),
        .busy(busy1), .halted(halted1), .illegal(ill1), .instr_count(cnt1)
    );

    typedef struct {
        int          cyc;
        int          dut;
        string       name;
        logic [70:0] v;
    } exp_t;

    exp_t q[$];
    int   pcnt   = 0;
    int   checks = 0;
    int   fails  = 0;

    always @(posedge clk) pcnt <= pcnt + 1;

    // Monitor: compare every expectation whose cycle has arrived
    always @(negedge clk) begin
        exp_t        e;
        logic [70:0] act;
        while (q.size() > 0 && q[0].cyc <= pcnt) begin
            e = q.pop_front();
            if (e.dut == 0)
                act = {stb0, op0, rin0, rout0, busy0, halted0, ill0, cnt0};
            else
                act = {stb1, op1, rin1, rout1, busy1, halted1, ill1, 14'd0, cnt1};
            checks++;
            if (e.cyc != pcnt || act !== e.v) begin
                fails++;
                $display("FAIL %s cyc=%0d got=%h required=%h", e.name, pcnt, act, e.v);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic ok);
        checks++;
        if (ok !== 1'b1) begin
            fails++;
            $display("FAIL %s cyc=%0d (direct check)", nm, pcnt);
        end
    endtask

    task automatic ex(input int d, input string nm, input logic [14:0] s, input logic [4:0] op,
                      input logic [15:0] ri, input logic [15:0] ro, input logic b,
                      input logic h, input logic il, input logic [15:0] c);
        exp_t e;
        e.cyc  = pcnt;
        e.dut  = d;
        e.name = nm;
        e.v    = {s, op, ri, ro, b, h, il, c};
        q.push_back(e);
    endtask

    task automatic fetch0(input string nm, input logic [15:0] c);
        tick(); ex(0, {nm, "_t0"}, E_T0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, c);
        tick(); ex(0, {nm, "_t1"}, E_T1, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, c);
        tick(); ex(0, {nm, "_t2"}, E_T2, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, c);
    endtask

    initial begin
        clear0 = 1'b1; clear1 = 1'b1; run0 = 1'b0; run1 = 1'b0; ir0 = '0; ir1 = '0;
        repeat (2) begin
            tick();
            ex(0, "reset", '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 16'd0);
            ex(1, "reset", '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 16'd0);
        end
        chk("reset_state",
            (stb0 === 15'd0) && (op0 === 5'd0) && (rin0 === 16'd0) && (rout0 === 16'd0) &&
            (busy0 === 1'b0) && (halted0 === 1'b0) && (ill0 === 1'b0) && (cnt0 === 16'd0) &&
            (stb1 === 15'd0) && (busy1 === 1'b0) && (cnt1 === 2'd0));
        clear0 = 1'b0; clear1 = 1'b0;
        repeat (10) begin
            tick(); ex(0, "idle_run0", '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 16'd0);
        end

        // AND R1,R2,R3
        ir0 = IR_AND; run0 = 1'b1;
        fetch0("and", 16'd0);
        tick(); ex(0, "and_t3", S_YIN, 5'd0, 16'h0, 16'h0004, 1'b1, 1'b0, 1'b0, 16'd0);
        tick(); ex(0, "and_t4", S_ZLOWIN, 5'b00010, 16'h0, 16'h0008, 1'b1, 1'b0, 1'b0, 16'd0);
        tick(); ex(0, "and_t5", S_ZLOWOUT, 5'd0, 16'h0002, 16'h0, 1'b1, 1'b0, 1'b0, 16'd0);
        run0 = 1'b0;
        tick(); ex(0, "and_idle", '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 16'd1);

        // MUL R4,R5,R6 with Run dropped mid-instruction
        ir0 = IR_MUL; run0 = 1'b1;
        tick(); ex(0, "mul_t0", E_T0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'd1);
        run0 = 1'b0;
        tick(); ex(0, "mul_t1", E_T1, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'd1);
        tick(); ex(0, "mul_t2", E_T2, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'd1);
        tick(); ex(0, "mul_t3", S_YIN, 5'd0, 16'h0, 16'h0020, 1'b1, 1'b0, 1'b0, 16'd1);
        tick(); ex(0, "mul_t4", S_ZLOWIN | S_ZHIGHIN, 5'b00100, 16'h0, 16'h0040, 1'b1, 1'b0, 1'b0, 16'd1);
        tick(); ex(0, "mul_t5", S_ZLOWOUT | S_LOIN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'd1);
        tick(); ex(0, "mul_t6", S_ZHIGHOUT | S_HIIN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'd1);
        tick(); ex(0, "mul_idle", '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 16'd2);

        // Illegal opcode retires and loops straight back to T0, then HALT
        ir0 = IR_ILL; run0 = 1'b1;
        fetch0("ill", 16'd2);
        tick(); ex(0, "ill_t3", '0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1, 16'd2);
        tick(); ex(0, "ill_next_t0", E_T0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'd3);
        ir0 = IR_HALT;
        tick(); ex(0, "halt_t1", E_T1, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'd3);
        tick(); ex(0, "halt_t2", E_T2, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'd3);
        tick(); ex(0, "halt_t3", '0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'd3);
        repeat (20) begin
            tick(); ex(0, "halted", '0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 16'd3);
        end

        // Clear out of HALTED, then Clear during T4 of SUB R0,R7,R15
        clear0 = 1'b1;
        tick(); ex(0, "clr_halted", '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 16'd0);
        clear0 = 1'b0; ir0 = IR_SUB;
        fetch0("sub", 16'd0);
        tick(); ex(0, "sub_t3", S_YIN, 5'd0, 16'h0, 16'h0080, 1'b1, 1'b0, 1'b0, 16'd0);
        tick(); ex(0, "sub_t4", S_ZLOWIN, 5'b00001, 16'h0, 16'h8000, 1'b1, 1'b0, 1'b0, 16'd0);
        clear0 = 1'b1;
        tick(); ex(0, "clr_t4", '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 16'd0);
        clear0 = 1'b0;
        fetch0("sub2", 16'd0);
        tick(); ex(0, "sub2_t3", S_YIN, 5'd0, 16'h0, 16'h0080, 1'b1, 1'b0, 1'b0, 16'd0);
        tick(); ex(0, "sub2_t4", S_ZLOWIN, 5'b00001, 16'h0, 16'h8000, 1'b1, 1'b0, 1'b0, 16'd0);
        tick(); ex(0, "sub2_t5_r0", S_ZLOWOUT, 5'd0, 16'h0001, 16'h0, 1'b1, 1'b0, 1'b0, 16'd0);
        run0 = 1'b0;
        tick(); ex(0, "sub2_idle", '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 16'd1);

        // MEM_WAIT=3 fetch timing and 2-bit counter wrap over four illegal instructions
        ir1 = IR_ILL; run1 = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            ex(1, "w_t0", E_T0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'(k));
            tick(); ex(1, "w_t1", E_T1, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'(k));
            repeat (3) begin
                tick(); ex(1, "w_t1w", E_T1W, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'(k));
            end
            chk("wait_last_t1w", (stb1 === E_T1W) && (busy1 === 1'b1));
            tick(); ex(1, "w_t2", E_T2, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'(k));
            chk("wait_expired", (stb1 === E_T2) && (stb1[0] === 1'b0));
            tick(); ex(1, "w_t3", '0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1, 16'(k));
            if (k == 3) run1 = 1'b0;
            tick();
        end
        ex(1, "w_wrap_idle", '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 16'd0);

        repeat (2) tick();
        chk("queue_drained", q.size() == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
